// File: rtl/median_pkg.sv
// Shared definitions for the 3x3 window generator: default image size,
// controller state encoding and the column-of-taps record.
package median_pkg;

   localparam int IMG_W_DEF = 640;
   localparam int IMG_H_DEF = 480;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_LINE = 2'd1,
      ACTIVE    = 2'd2,
      LINE_END  = 2'd3
   } win_state_t;

   typedef struct packed {
      logic [7:0] top;
      logic [7:0] mid;
      logic [7:0] bot;
   } tap_col_t;

endpackage

// File: rtl/line_buf_ram.sv
// Single-clock line buffer: one synchronous write port and one registered,
// read-first read port.
module line_buf_ram #(
   parameter int DEPTH = 640,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data
);

   logic [7:0] mem [DEPTH];

   // Non-blocking read and write on the same edge gives the old contents on a collision.
   always_ff @(posedge clk) begin
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

endmodule

// File: rtl/median_window_ctrl.sv
// Builds a zero-padded 3x3 pixel window from a raster stream using two line
// buffers, with line/frame tracking, length checking and a frame-done pulse.
module median_window_ctrl import median_pkg::*; #(
   parameter int IMG_W = IMG_W_DEF,
   parameter int IMG_H = IMG_H_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       per_frame_vsync,
   input  logic       per_frame_href,
   input  logic       per_frame_clken,
   input  logic [7:0] per_img_y,
   output logic       matrix_frame_vsync,
   output logic       matrix_frame_href,
   output logic       matrix_frame_clken,
   output logic [7:0] matrix_p11,
   output logic [7:0] matrix_p12,
   output logic [7:0] matrix_p13,
   output logic [7:0] matrix_p21,
   output logic [7:0] matrix_p22,
   output logic [7:0] matrix_p23,
   output logic [7:0] matrix_p31,
   output logic [7:0] matrix_p32,
   output logic [7:0] matrix_p33,
   output logic       frame_done,
   output logic       line_err
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   win_state_t    state;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic          line_full;
   logic          last_line;
   logic          vsync_prev;
   logic          href_prev;

   logic vsync_rise;
   logic href_rise;
   logic href_fall;
   logic in_line;
   logic accept;
   logic wr_pix;
   logic extra_pix;

   logic [7:0]    lb1_q;
   logic [7:0]    lb2_q;
   logic          s1_valid;
   logic [7:0]    s1_pix;
   logic [CW-1:0] s1_col;
   logic          s1_row1;
   logic          s1_row2;
   logic          s1_col0;

   tap_col_t   new_col;
   tap_col_t   col1;
   tap_col_t   col2;
   tap_col_t   col3;
   logic [1:0] vsync_d;
   logic [1:0] href_d;
   logic [1:0] clken_d;

   assign vsync_rise = per_frame_vsync && !vsync_prev;
   assign href_rise  = per_frame_href && !href_prev;
   assign href_fall  = !per_frame_href && href_prev;

   // A line is only picked up from its first pixel, so a restart mid-line waits for the next href.
   assign in_line   = (state == ACTIVE) || ((state == WAIT_LINE) && href_rise);
   assign accept    = per_frame_href && per_frame_clken && in_line && !vsync_rise;
   assign wr_pix    = accept && !line_full;
   assign extra_pix = accept && line_full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         col        <= '0;
         row        <= '0;
         line_full  <= 1'b0;
         last_line  <= 1'b0;
         vsync_prev <= 1'b0;
         href_prev  <= 1'b0;
         frame_done <= 1'b0;
         line_err   <= 1'b0;
      end else begin
         vsync_prev <= per_frame_vsync;
         href_prev  <= per_frame_href;
         frame_done <= wr_pix && (row == ROW_LAST) && (col == COL_LAST);
         if (vsync_rise) begin
            state     <= WAIT_LINE;
            col       <= '0;
            row       <= '0;
            line_full <= 1'b0;
            last_line <= 1'b0;
            line_err  <= 1'b0;
         end else begin
            if (wr_pix) begin
               if (col == COL_LAST) begin
                  line_full <= 1'b1;
               end else begin
                  col <= col + CW'(1);
               end
            end
            if (extra_pix) begin
               line_err <= 1'b1;
            end
            case (state)
               IDLE: state <= IDLE;
               WAIT_LINE: begin
                  if (href_rise) begin
                     state <= ACTIVE;
                  end
               end
               ACTIVE: begin
                  if (href_fall) begin
                     state     <= LINE_END;
                     col       <= '0;
                     line_full <= 1'b0;
                     last_line <= (row == ROW_LAST);
                     if (row != ROW_LAST) begin
                        row <= row + RW'(1);
                     end
                     if (!line_full) begin
                        line_err <= 1'b1;
                     end
                  end
               end
               LINE_END: state <= last_line ? IDLE : WAIT_LINE;
               default:  state <= IDLE;
            endcase
         end
      end
   end

   // LB2 takes LB1's old word one cycle after the read, which is the same
   // shift as a same-cycle copy because the next access is always to another column.
   line_buf_ram #(.DEPTH(IMG_W), .AW(CW)) u_lb1 (
      .clk     (clk),
      .wr_en   (wr_pix),
      .wr_addr (col),
      .wr_data (per_img_y),
      .rd_en   (wr_pix),
      .rd_addr (col),
      .rd_data (lb1_q)
   );

   line_buf_ram #(.DEPTH(IMG_W), .AW(CW)) u_lb2 (
      .clk     (clk),
      .wr_en   (s1_valid),
      .wr_addr (s1_col),
      .wr_data (lb1_q),
      .rd_en   (wr_pix),
      .rd_addr (col),
      .rd_data (lb2_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_pix   <= '0;
         s1_col   <= '0;
         s1_row1  <= 1'b0;
         s1_row2  <= 1'b0;
         s1_col0  <= 1'b0;
      end else begin
         s1_valid <= wr_pix;
         if (wr_pix) begin
            s1_pix  <= per_img_y;
            s1_col  <= col;
            s1_row1 <= (row != '0);
            s1_row2 <= (row > RW'(1));
            s1_col0 <= (col == '0);
         end
      end
   end

   // Rows above the top of the frame read as zero instead of stale buffer data.
   always_comb begin
      new_col     = '0;
      new_col.top = s1_row2 ? lb2_q : 8'd0;
      new_col.mid = s1_row1 ? lb1_q : 8'd0;
      new_col.bot = s1_pix;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col1    <= '0;
         col2    <= '0;
         col3    <= '0;
         vsync_d <= '0;
         href_d  <= '0;
         clken_d <= '0;
      end else begin
         vsync_d <= {vsync_d[0], per_frame_vsync};
         href_d  <= {href_d[0], per_frame_href};
         clken_d <= {clken_d[0], per_frame_clken};
         if (s1_valid) begin
            col3 <= new_col;
            col2 <= s1_col0 ? '0 : col3;
            col1 <= s1_col0 ? '0 : col2;
         end
      end
   end

   assign matrix_frame_vsync = vsync_d[1];
   assign matrix_frame_href  = href_d[1];
   assign matrix_frame_clken = clken_d[1];

   assign matrix_p11 = col1.top;
   assign matrix_p12 = col2.top;
   assign matrix_p13 = col3.top;
   assign matrix_p21 = col1.mid;
   assign matrix_p22 = col2.mid;
   assign matrix_p23 = col3.mid;
   assign matrix_p31 = col1.bot;
   assign matrix_p32 = col2.bot;
   assign matrix_p33 = col3.bot;

endmodule

// File: doc/median_window_ctrl.md
MEDIAN_WINDOW_CTRL -- requirements
Module: median_window_ctrl

Interface
REQ-001 SHALL use parameter: IMG_W, 640, active pixels per line (range 4..2048).
REQ-002 SHALL use parameter: IMG_H, 480, active lines per frame (range 3..2048).
REQ-003 SHALL have port: clk  input  1  pixel clock; all logic on its rising edge.
REQ-004 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: per_frame_vsync, per_frame_href, per_frame_clken  input  1 each  input stream timing; a pixel is accepted when href && clken.
REQ-006 SHALL have port: per_img_y  input  8  input pixel.
REQ-007 SHALL have ports: matrix_frame_vsync, matrix_frame_href, matrix_frame_clken  output  1 each  window-stream timing.
REQ-008 SHALL have ports: matrix_p11..matrix_p33  output  8 each  3x3 window taps; row 1 = oldest line, row 3 = current line; column 1 = oldest pixel, column 3 = newest pixel.
REQ-009 SHALL have port: frame_done  output  1  one-cycle pulse after the last pixel of the final line of a frame is accepted.
REQ-010 SHALL have port: line_err  output  1  sticky flag: a line had a pixel count other than IMG_W; cleared by a vsync rising edge.

Function
REQ-011 SHALL keep a column counter col (0..IMG_W-1) that increments on each accepted pixel and clears on href falling edge.
REQ-012 SHALL keep a row counter row (0..IMG_H-1) that increments on href falling edge and clears on vsync rising edge.
REQ-013 SHALL run a state machine with states IDLE, WAIT_LINE, ACTIVE and LINE_END.
- IDLE -> WAIT_LINE on vsync rising edge.
- WAIT_LINE -> ACTIVE on href rising edge.
- ACTIVE -> LINE_END on href falling edge.
- LINE_END -> WAIT_LINE after one cycle, or -> IDLE when row = IMG_H-1.
REQ-014 SHALL restart from WAIT_LINE on a vsync rising edge seen in any state, clearing row and col.
REQ-015 SHALL keep two line buffers of IMG_W x 8 bits, LB1 (line r-1) and LB2 (line r-2), both addressed by col.
REQ-016 SHALL, on each accepted pixel, read LB1[col] and LB2[col] read-first, then write LB2[col] <= old LB1[col] and LB1[col] <= per_img_y in the same cycle.
REQ-017 SHALL, for the pixel accepted at (row r, col c) in cycle T, present in cycle T+2:
- p33 = pixel(r,c), p23 = pixel(r-1,c), p13 = pixel(r-2,c);
- columns 2 and 1 hold columns c-1 and c-2 of the same three rows.
REQ-018 SHALL output 0 for every tap with a negative row or column index: rows 1..2 are zero when r=0, row 1 is zero when r=1; columns 1..2 are zero when c=0, column 1 is zero when c=1.
REQ-019 SHALL delay matrix_frame_vsync/href/clken by exactly 2 cycles relative to the per_frame_* inputs.
REQ-020 SHALL hold the taps when no pixel is accepted (clken low).
REQ-021 SHALL assert line_err when a line ends with col != IMG_W, or when a pixel arrives with col = IMG_W-1 already reached; extra pixels are dropped (no buffer write).
REQ-022 SHALL raise frame_done in the cycle after the accepted pixel with row = IMG_H-1 and col = IMG_W-1.

Reset
REQ-023 SHALL, while rst_n is low, asynchronously clear all outputs, counters, tap registers and delay lines to 0 and set the state to IDLE; line-buffer contents are don't-care because of the zero-fill in REQ-018.
REQ-024 SHALL, when reset is asserted mid-frame, resume only at the next vsync rising edge.

Structure
REQ-025 SHALL place state encodings and the IMG_W/IMG_H defaults in shared package median_pkg.
REQ-026 SHALL implement each line buffer as one sub-module, line_buf_ram (single-clock, read-first, 1 write + 1 read port), instantiated twice.

Verification
REQ-027 SHALL cover: IMG_W=4, IMG_H=3, pixel value = 16*row+col -> at input (2,3), two cycles later p11..p33 = 01,02,03,11,12,13,21,22,23 (hex).
REQ-028 SHALL cover: first pixel (0,0) = 0x55 -> two cycles later p33 = 0x55 and all other taps = 0.
REQ-029 SHALL cover: line 1 carrying only 3 pixels with IMG_W=4 -> line_err = 1 from line end until the next vsync rising edge, then 0.
REQ-030 SHALL cover: clken gapped 1-of-3 within a line -> tap sequence identical to the gap-free case; matrix_frame_clken pattern equals the input pattern delayed 2 cycles.
REQ-031 SHALL cover: rst_n pulsed low mid-line -> all outputs read 0 immediately; the next frame after vsync produces correct windows.
REQ-032 SHALL cover: last pixel (IMG_H-1, IMG_W-1) -> exactly one frame_done pulse per frame.
